// File: rtl/hold_counter.sv
// Up-counter with hold and synchronous clear, used as a wait-state/delay timer.
// Build option HOLD_COUNTER_AUTOHOLD_EN: the counter saturates at all-ones instead of wrapping.
module hold_counter #(
    parameter int SIZE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            hold,
    output logic [SIZE-1:0] cntr,
    output logic            at_max
);

    logic hold_eff;

    assign at_max = &cntr;

`ifdef HOLD_COUNTER_AUTOHOLD_EN
    // Reaching all-ones freezes the count until clear or reset.
    assign hold_eff = hold | at_max;
`else
    assign hold_eff = hold;
`endif

    // Priority: clear beats hold, hold beats increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cntr <= '0;
        end else if (clear) begin
            cntr <= '0;
        end else if (!hold_eff) begin
            cntr <= cntr + SIZE'(1);
        end
    end

endmodule

// File: tb/tb_hold_counter.sv
// Bench for hold_counter: a 4-bit and a 1-bit instance checked against an arithmetic model.
module tb_hold_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       c4, h4, c1, h1;
    logic [3:0] cntr4;
    logic       am4;
    logic [0:0] cntr1;
    logic       am1;

`ifdef HOLD_COUNTER_AUTOHOLD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    int         m4, m1;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] exp_w;

    always #5 clock = ~clock;

    hold_counter #(.SIZE(4)) dut4 (
        .clock (clock), .reset (reset), .clear (c4), .hold (h4),
        .cntr  (cntr4), .at_max (am4)
    );

    hold_counter #(.SIZE(1)) dut1 (
        .clock (clock), .reset (reset), .clear (c1), .hold (h1),
        .cntr  (cntr1), .at_max (am1)
    );

    function automatic logic [6:0] model_word();
        return {4'(m4), (m4 == 15), 1'(m1), (m1 == 1)};
    endfunction

    // One rising edge: advance the model by the counter rules, then settle to the falling edge.
    task automatic tick();
        bit eff4, eff1;
        @(posedge clock);
        if (reset) begin
            eff4 = h4 | (AUTO && m4 == 15);
            eff1 = h1 | (AUTO && m1 == 1);
            if (c4)        m4 = 0;
            else if (!eff4) m4 = (m4 + 1) % 16;
            if (c1)        m1 = 0;
            else if (!eff1) m1 = (m1 + 1) % 2;
        end
        @(negedge clock);
        exp_q.push_back(model_word());
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({cntr4, am4, cntr1, am1} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_initial: got %b expected %b", {cntr4, am4, cntr1, am1}, 7'b0);
        end
        @(negedge clock);
        c4 = 0; h4 = 0; c1 = 0; h1 = 0;
        reset = 1'b1;
        m4 = 0; m1 = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_w = exp_q.pop_front();
            n_checks++;
            if ({cntr4, am4, cntr1, am1} !== exp_w) begin
                n_errors++;
                $display("FAIL reset_count edge %0d: got %b expected %b", i, {cntr4, am4, cntr1, am1}, exp_w);
            end
        end
        n_checks++;
        if (cntr4 !== 4'd7) begin
            n_errors++;
            $display("FAIL reset_precount: got %0d expected 7", cntr4);
        end
        #2 reset = 1'b0;
        m4 = 0; m1 = 0;
        #1;
        n_checks++;
        if ({cntr4, am4} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_async: got cntr=%0d at_max=%b expected 0/0", cntr4, am4);
        end
        h4 = 1'bx; c4 = 1'bx; h1 = 1'bx; c1 = 1'bx;
        @(posedge clock);
        #1;
        n_checks++;
        if ({cntr4, am4, cntr1, am1} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_x_inputs: got %b expected %b", {cntr4, am4, cntr1, am1}, 7'b0);
        end
        @(negedge clock);
        c4 = 0; h4 = 0; c1 = 0; h1 = 0;
        reset = 1'b1;
        tick();
        exp_w = exp_q.pop_front();
        n_checks++;
        if (cntr4 !== 4'd1 || {cntr4, am4, cntr1, am1} !== exp_w) begin
            n_errors++;
            $display("FAIL reset_resume: got %b expected %b", {cntr4, am4, cntr1, am1}, exp_w);
        end
    endtask

    task automatic test_saturate();
        c4 = 1; h4 = 0;
        tick();
        exp_w = exp_q.pop_front();
        n_checks++;
        if (cntr4 !== 4'd0 || {cntr4, am4, cntr1, am1} !== exp_w) begin
            n_errors++;
            $display("FAIL sat_clear: got %b expected %b", {cntr4, am4, cntr1, am1}, exp_w);
        end
        c4 = 0;
        for (int i = 1; i <= 25; i++) begin
            h4 = (m4 == 15);
            tick();
            exp_w = exp_q.pop_front();
            n_checks++;
            if ({cntr4, am4, cntr1, am1} !== exp_w || cntr4 !== 4'((i < 15) ? i : 15)
                || am4 !== (i >= 15)) begin
                n_errors++;
                $display("FAIL saturate edge %0d: got cntr=%0d at_max=%b expected cntr=%0d at_max=%b",
                         i, cntr4, am4, (i < 15) ? i : 15, (i >= 15));
            end
        end
        h4 = 0;
    endtask

    task automatic test_wrap();
        int seq[3];
        if (AUTO) seq = '{15, 15, 15};
        else      seq = '{15, 0, 1};
        c4 = 1; h4 = 0;
        tick();
        void'(exp_q.pop_front());
        c4 = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp_w = exp_q.pop_front();
            n_checks++;
            if ({cntr4, am4, cntr1, am1} !== exp_w) begin
                n_errors++;
                $display("FAIL wrap_ramp edge %0d: got %b expected %b", i, {cntr4, am4, cntr1, am1}, exp_w);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_w = exp_q.pop_front();
            n_checks++;
            if (cntr4 !== 4'(seq[i]) || am4 !== (seq[i] == 15) || {cntr4, am4, cntr1, am1} !== exp_w) begin
                n_errors++;
                $display("FAIL wrap step %0d: got cntr=%0d at_max=%b expected cntr=%0d", i, cntr4, am4, seq[i]);
            end
        end
    endtask

    task automatic test_hold();
        c4 = 1; h4 = 0;
        tick();
        void'(exp_q.pop_front());
        c4 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            void'(exp_q.pop_front());
        end
        h4 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_w = exp_q.pop_front();
            n_checks++;
            if (cntr4 !== 4'd5 || {cntr4, am4, cntr1, am1} !== exp_w) begin
                n_errors++;
                $display("FAIL hold edge %0d: got cntr=%0d expected 5", i, cntr4);
            end
        end
        h4 = 0;
        tick();
        exp_w = exp_q.pop_front();
        n_checks++;
        if (cntr4 !== 4'd6 || {cntr4, am4, cntr1, am1} !== exp_w) begin
            n_errors++;
            $display("FAIL hold_release: got cntr=%0d expected 6", cntr4);
        end
    endtask

    task automatic test_clear_priority();
        c4 = 1; h4 = 0;
        tick();
        void'(exp_q.pop_front());
        c4 = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (cntr4 !== 4'd15 || am4 !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_setup: got cntr=%0d at_max=%b expected 15/1", cntr4, am4);
        end
        c4 = 1; h4 = 1;
        tick();
        exp_w = exp_q.pop_front();
        n_checks++;
        if (cntr4 !== 4'd0 || am4 !== 1'b0 || {cntr4, am4, cntr1, am1} !== exp_w) begin
            n_errors++;
            $display("FAIL clr_over_hold: got cntr=%0d at_max=%b expected 0/0", cntr4, am4);
        end
        c4 = 0; h4 = 0;
        tick();
        exp_w = exp_q.pop_front();
        n_checks++;
        if (cntr4 !== 4'd1 || {cntr4, am4, cntr1, am1} !== exp_w) begin
            n_errors++;
            $display("FAIL clr_resume: got cntr=%0d expected 1", cntr4);
        end
    endtask

    task automatic test_size1();
        logic [0:0] seq[3];
        seq = '{1'b0, 1'b1, AUTO ? 1'b1 : 1'b0};
        c1 = 1; h1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            c1 = 0;
            exp_w = exp_q.pop_front();
            n_checks++;
            if (cntr1 !== seq[i] || am1 !== seq[i] || {cntr4, am4, cntr1, am1} !== exp_w) begin
                n_errors++;
                $display("FAIL size1 step %0d: got cntr=%b at_max=%b expected %b", i, cntr1, am1, seq[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            c4 = ($urandom_range(0, 9) == 0);
            h4 = ($urandom_range(0, 3) == 0);
            c1 = ($urandom_range(0, 5) == 0);
            h1 = ($urandom_range(0, 2) == 0);
            tick();
            exp_w = exp_q.pop_front();
            n_checks++;
            if ({cntr4, am4, cntr1, am1} !== exp_w) begin
                n_errors++;
                $display("FAIL random edge %0d: got %b expected %b", i, {cntr4, am4, cntr1, am1}, exp_w);
            end
        end
        c4 = 0; h4 = 0; c1 = 0; h1 = 0;
    endtask

    initial begin
        c4 = 0; h4 = 0; c1 = 0; h1 = 0;
        m4 = 0; m1 = 0;
        test_reset();
        test_saturate();
        test_wrap();
        test_hold();
        test_clear_priority();
        test_size1();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
